// File: rtl/integer_issue_queue.sv
// ---------------------------------------------------------------------------
// integer_issue_queue
//
// Holds dispatched integer instructions until both source operands are
// available. Each cycle it issues one ready instruction, oldest first, to the
// integer execute stage. Execute applies no back-pressure.
//
// Storage is a collapsing queue. Slot 0 is the oldest entry, and valid slots
// are always contiguous from slot 0. Because of that, a slot's validity is
// simply (index < occupancy) and needs no per-slot valid flop.
//
// Ports
//   clk                   clock
//   rst_aL                synchronous reset, active low
//   dispatch_valid/ready  dispatch handshake (ready = queue not full)
//   dispatch_data         payload plus per-source ready/rob_id/data
//   alu_broadcast_*       ALU result broadcast (valid, producer tag, value)
//   ld_broadcast_*        load result broadcast (valid, producer tag, value)
//   flush                 drops every queued entry and any concurrent enqueue
//   iiq_issue_data        issued instruction, qualified by entry_valid
//   iiq_count             current occupancy
// ---------------------------------------------------------------------------
package integer_issue_queue_pkg;

  typedef logic [5:0]  rob_id_t;
  typedef logic [31:0] reg_data_t;

  // Dispatch payload. It is also the per-slot storage format.
  typedef struct packed {
    rob_id_t     instr_rob_id;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [2:0]  funct3;
    logic        is_r_type;
    logic        is_i_type;
    logic        is_u_type;
    logic        is_b_type;
    logic        is_j_type;
    logic        is_sub;
    logic        is_sra_srai;
    logic        is_lui;
    logic        is_jalr;
    logic        br_dir_pred;
    logic        src1_ready;
    rob_id_t     src1_rob_id;
    reg_data_t   src1_data;
    logic        src2_ready;
    rob_id_t     src2_rob_id;
    reg_data_t   src2_data;
  } iiq_dispatch_data_t;

  typedef struct packed {
    logic        entry_valid;
    rob_id_t     instr_rob_id;
    reg_data_t   src1_data;
    reg_data_t   src2_data;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [2:0]  funct3;
    logic        is_r_type;
    logic        is_i_type;
    logic        is_u_type;
    logic        is_b_type;
    logic        is_j_type;
    logic        is_sub;
    logic        is_sra_srai;
    logic        is_lui;
    logic        is_jalr;
    logic        br_dir_pred;
  } iiq_issue_data_t;

endpackage

module integer_issue_queue
  import integer_issue_queue_pkg::*;
#(
  parameter int N_ENTRIES = 8,
  parameter int CNT_WIDTH = $clog2(N_ENTRIES + 1)
) (
  input  logic                 clk,
  input  logic                 rst_aL,
  input  logic                 dispatch_valid,
  output logic                 dispatch_ready,
  input  iiq_dispatch_data_t   dispatch_data,
  input  logic                 alu_broadcast_valid,
  input  rob_id_t              alu_broadcast_rob_id,
  input  reg_data_t            alu_broadcast_data,
  input  logic                 ld_broadcast_valid,
  input  rob_id_t              ld_broadcast_rob_id,
  input  reg_data_t            ld_broadcast_data,
  input  logic                 flush,
  output iiq_issue_data_t      iiq_issue_data,
  output logic [CNT_WIDTH-1:0] iiq_count
);

  localparam int IDX_W = $clog2(N_ENTRIES);

  // Slot storage and its next-state pipeline: collapse -> insert -> wakeup.
  iiq_dispatch_data_t slot_reg     [N_ENTRIES];
  iiq_dispatch_data_t slot_next    [N_ENTRIES];
  iiq_dispatch_data_t slot_shifted [N_ENTRIES];
  iiq_dispatch_data_t slot_placed  [N_ENTRIES];

  logic [CNT_WIDTH-1:0] count_reg;
  logic [CNT_WIDTH-1:0] count_next;
  logic [CNT_WIDTH-1:0] tail_idx;

  logic [N_ENTRIES-1:0] slot_valid;
  logic [N_ENTRIES-1:0] issuable;
  logic [N_ENTRIES-1:0] shift_mask;
  logic                 issue_hit;
  logic [IDX_W-1:0]     issue_idx;
  logic                 enq;

  // Operand capture for one entry. Only sources that are still waiting look
  // at the broadcasts. The ALU bus is checked first, so it wins if both buses
  // carry the same tag.
  function automatic iiq_dispatch_data_t wake(
    input iiq_dispatch_data_t e,
    input logic               av,
    input rob_id_t            at,
    input reg_data_t          ad,
    input logic               lv,
    input rob_id_t            lt,
    input reg_data_t          ld
  );
    iiq_dispatch_data_t w;
    w = e;
    if (!e.src1_ready) begin
      if (av && (at == e.src1_rob_id)) begin
        w.src1_ready = 1'b1;
        w.src1_data  = ad;
      end else if (lv && (lt == e.src1_rob_id)) begin
        w.src1_ready = 1'b1;
        w.src1_data  = ld;
      end
    end
    if (!e.src2_ready) begin
      if (av && (at == e.src2_rob_id)) begin
        w.src2_ready = 1'b1;
        w.src2_data  = ad;
      end else if (lv && (lt == e.src2_rob_id)) begin
        w.src2_ready = 1'b1;
        w.src2_data  = ld;
      end
    end
    return w;
  endfunction

  // Full is judged on registered occupancy only. A slot freed by this
  // cycle's issue is not offered to dispatch until the next cycle.
  assign dispatch_ready = (count_reg != CNT_WIDTH'(N_ENTRIES));
  assign enq            = dispatch_valid & dispatch_ready & ~flush;

  // Tail after this cycle's collapse. New entries land here.
  assign tail_idx   = count_reg - CNT_WIDTH'(issue_hit);
  assign count_next = tail_idx + CNT_WIDTH'(enq);

  // Oldest-first select. Scan from the top so the last hit is the lowest index.
  always_comb begin
    issue_hit = 1'b0;
    issue_idx = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (issuable[i]) begin
        issue_hit = 1'b1;
        issue_idx = IDX_W'(i);
      end
    end
  end

  // Slots at or above the issued one take their upper neighbour's contents.
  always_comb begin
    shift_mask = '0;
    if (issue_hit) begin
      shift_mask = ~((N_ENTRIES'(1) << issue_idx) - N_ENTRIES'(1));
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_ENTRIES; gi++) begin : g_slot
      assign slot_valid[gi] = (CNT_WIDTH'(gi) < count_reg);
      assign issuable[gi]   = slot_valid[gi]
                            & slot_reg[gi].src1_ready
                            & slot_reg[gi].src2_ready;

      // The top slot has nothing above it. When it shifts, it falls past the
      // new tail, and its stale contents are never observed.
      if (gi < N_ENTRIES - 1) begin : g_shift
        assign slot_shifted[gi] = shift_mask[gi] ? slot_reg[gi+1] : slot_reg[gi];
      end else begin : g_top
        assign slot_shifted[gi] = slot_reg[gi];
      end

      assign slot_placed[gi] = (enq && (tail_idx == CNT_WIDTH'(gi)))
                             ? dispatch_data : slot_shifted[gi];

      // Wakeup is applied after the collapse and the insert. A moving entry
      // keeps a capture made on this edge, and a freshly dispatched entry
      // snoops the broadcasts of its own dispatch cycle.
      assign slot_next[gi] = wake(slot_placed[gi],
                                  alu_broadcast_valid, alu_broadcast_rob_id,
                                  alu_broadcast_data,
                                  ld_broadcast_valid, ld_broadcast_rob_id,
                                  ld_broadcast_data);
    end
  endgenerate

  // Slot contents need no reset. Occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_ENTRIES; i++) begin
      slot_reg[i] <= slot_next[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_aL || flush) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign iiq_count = count_reg;

  // The issued slot is read straight from the registered state. A flush cycle
  // still presents it, and the ROB discards it.
  always_comb begin
    iiq_issue_data              = '0;
    iiq_issue_data.entry_valid  = issue_hit;
    iiq_issue_data.instr_rob_id = slot_reg[issue_idx].instr_rob_id;
    iiq_issue_data.src1_data    = slot_reg[issue_idx].src1_data;
    iiq_issue_data.src2_data    = slot_reg[issue_idx].src2_data;
    iiq_issue_data.imm          = slot_reg[issue_idx].imm;
    iiq_issue_data.pc           = slot_reg[issue_idx].pc;
    iiq_issue_data.funct3       = slot_reg[issue_idx].funct3;
    iiq_issue_data.is_r_type    = slot_reg[issue_idx].is_r_type;
    iiq_issue_data.is_i_type    = slot_reg[issue_idx].is_i_type;
    iiq_issue_data.is_u_type    = slot_reg[issue_idx].is_u_type;
    iiq_issue_data.is_b_type    = slot_reg[issue_idx].is_b_type;
    iiq_issue_data.is_j_type    = slot_reg[issue_idx].is_j_type;
    iiq_issue_data.is_sub       = slot_reg[issue_idx].is_sub;
    iiq_issue_data.is_sra_srai  = slot_reg[issue_idx].is_sra_srai;
    iiq_issue_data.is_lui       = slot_reg[issue_idx].is_lui;
    iiq_issue_data.is_jalr      = slot_reg[issue_idx].is_jalr;
    iiq_issue_data.br_dir_pred  = slot_reg[issue_idx].br_dir_pred;
  end

  // Occupancy can never leave [0, N_ENTRIES]. Enqueue is gated by full, and
  // issue requires a valid slot.
  always @(posedge clk) begin
    if (rst_aL && !flush) begin
      assert (!(enq && !issue_hit && (count_reg == CNT_WIDTH'(N_ENTRIES))));
      assert (!(issue_hit && !enq && (count_reg == '0)));
    end
  end

endmodule

// File: tb/tb_integer_issue_queue.sv
`timescale 1ns/1ps
module tb_integer_issue_queue;
  import integer_issue_queue_pkg::*;

  localparam int N  = 8;
  localparam int CW = $clog2(N + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_aL;
  logic               dispatch_valid;
  logic               dispatch_ready;
  iiq_dispatch_data_t dispatch_data;
  logic               alu_v, ld_v, flush;
  rob_id_t            alu_t, ld_t;
  reg_data_t          alu_d, ld_d;
  iiq_issue_data_t    iss;
  logic [CW-1:0]      count;

  integer_issue_queue #(.N_ENTRIES(N)) dut (
    .clk                  (clk),
    .rst_aL               (rst_aL),
    .dispatch_valid       (dispatch_valid),
    .dispatch_ready       (dispatch_ready),
    .dispatch_data        (dispatch_data),
    .alu_broadcast_valid  (alu_v),
    .alu_broadcast_rob_id (alu_t),
    .alu_broadcast_data   (alu_d),
    .ld_broadcast_valid   (ld_v),
    .ld_broadcast_rob_id  (ld_t),
    .ld_broadcast_data    (ld_d),
    .flush                (flush),
    .iiq_issue_data       (iss),
    .iiq_count            (count)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: an age-ordered list ----------------
  typedef struct {
    logic [5:0]  rob;
    logic        s1r;
    logic [5:0]  s1t;
    logic [31:0] s1d;
    logic        s2r;
    logic [5:0]  s2t;
    logic [31:0] s2d;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic [9:0]  fl;
  } ment_t;

  ment_t mq[$];
  bit    model_live = 0;

  function automatic int model_pick();
    foreach (mq[i]) if (mq[i].s1r && mq[i].s2r) return i;
    return -1;
  endfunction

  function automatic logic [9:0] iss_flags();
    return {iss.is_r_type, iss.is_i_type, iss.is_u_type, iss.is_b_type, iss.is_j_type,
            iss.is_sub, iss.is_sra_srai, iss.is_lui, iss.is_jalr, iss.br_dir_pred};
  endfunction

  task automatic check_model();
    int p;
    p = model_pick();
    chk("m_count", 32'(count), 32'(mq.size()));
    chk("m_ready", 32'(dispatch_ready), 32'(mq.size() != N));
    chk("m_valid", 32'(iss.entry_valid), 32'(p >= 0));
    if (p >= 0 && iss.entry_valid) begin
      chk("m_rob",    32'(iss.instr_rob_id), 32'(mq[p].rob));
      chk("m_src1",   iss.src1_data,         mq[p].s1d);
      chk("m_src2",   iss.src2_data,         mq[p].s2d);
      chk("m_pc",     iss.pc,                mq[p].pc);
      chk("m_imm",    iss.imm,               mq[p].imm);
      chk("m_funct3", 32'(iss.funct3),       32'(mq[p].f3));
      chk("m_flags",  32'(iss_flags()),      32'(mq[p].fl));
    end
  endtask

  // Applies the edge: flush/reset empties the list; otherwise the oldest
  // ready entry leaves, a dispatch joins if the list was not full at the
  // start of the cycle, and then every waiting source looks at the buses.
  task automatic model_update();
    int p, sz;
    if (!rst_aL || flush) begin
      mq.delete();
      if (!rst_aL) model_live = 1;
    end else begin
      sz = mq.size();
      p  = model_pick();
      if (p >= 0) mq.delete(p);
      if (dispatch_valid && sz < N) begin
        ment_t e;
        e.rob = dispatch_data.instr_rob_id;
        e.s1r = dispatch_data.src1_ready;  e.s1t = dispatch_data.src1_rob_id;  e.s1d = dispatch_data.src1_data;
        e.s2r = dispatch_data.src2_ready;  e.s2t = dispatch_data.src2_rob_id;  e.s2d = dispatch_data.src2_data;
        e.pc  = dispatch_data.pc;  e.imm = dispatch_data.imm;  e.f3 = dispatch_data.funct3;
        e.fl  = {dispatch_data.is_r_type, dispatch_data.is_i_type, dispatch_data.is_u_type,
                 dispatch_data.is_b_type, dispatch_data.is_j_type, dispatch_data.is_sub,
                 dispatch_data.is_sra_srai, dispatch_data.is_lui, dispatch_data.is_jalr,
                 dispatch_data.br_dir_pred};
        mq.push_back(e);
      end
      foreach (mq[i]) begin
        if (!mq[i].s1r) begin
          if (alu_v && alu_t == mq[i].s1t)     begin mq[i].s1r = 1; mq[i].s1d = alu_d; end
          else if (ld_v && ld_t == mq[i].s1t)  begin mq[i].s1r = 1; mq[i].s1d = ld_d;  end
        end
        if (!mq[i].s2r) begin
          if (alu_v && alu_t == mq[i].s2t)     begin mq[i].s2r = 1; mq[i].s2d = alu_d; end
          else if (ld_v && ld_t == mq[i].s2t)  begin mq[i].s2r = 1; mq[i].s2d = ld_d;  end
        end
      end
    end
  endtask

  task automatic drive(input logic dv, input int rob, input logic s1r, input int s1t,
                       input logic [31:0] s1d, input logic s2r, input int s2t,
                       input logic [31:0] s2d, input logic [31:0] pc, input logic [31:0] imm);
    logic [5:0] r;
    r = 6'(rob);
    dispatch_valid             = dv;
    dispatch_data              = '0;
    dispatch_data.instr_rob_id = r;
    dispatch_data.imm          = imm;
    dispatch_data.pc           = pc;
    dispatch_data.funct3       = r[2:0] ^ 3'b101;
    dispatch_data.is_r_type    = r[0];
    dispatch_data.is_i_type    = r[1];
    dispatch_data.is_u_type    = r[2];
    dispatch_data.is_b_type    = r[3];
    dispatch_data.is_j_type    = r[4];
    dispatch_data.is_sub       = r[5];
    dispatch_data.is_sra_srai  = r[0] ^ r[1];
    dispatch_data.is_lui       = r[1] ^ r[2];
    dispatch_data.is_jalr      = r[2] ^ r[3];
    dispatch_data.br_dir_pred  = r[3] ^ r[4];
    dispatch_data.src1_ready   = s1r;
    dispatch_data.src1_rob_id  = 6'(s1t);
    dispatch_data.src1_data    = s1d;
    dispatch_data.src2_ready   = s2r;
    dispatch_data.src2_rob_id  = 6'(s2t);
    dispatch_data.src2_data    = s2d;
  endtask

  // ---------------- directed vectors ----------------
  // Expected fields describe the outputs in the cycle the inputs are applied.
  // Ready sources carry 0x100+rob (src1) and 0x200+rob (src2).
  typedef struct {
    bit          chk;
    logic        rst_n;
    logic        fl;
    logic        dv;
    int          rob;
    logic        s1r;
    int          s1t;
    logic        s2r;
    int          s2t;
    logic        av;
    int          at;
    logic [31:0] ad;
    logic        lv;
    int          lt;
    logic [31:0] ld;
    logic        e_valid;
    int          e_rob;
    logic [31:0] e_s1;
    logic [31:0] e_s2;
    int          e_cnt;
    logic        e_rdy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit c, logic r, logic f, logic dv, int rob, logic s1r, int s1t,
                              logic s2r, int s2t, logic av, int at, logic [31:0] ad,
                              logic lv, int lt, logic [31:0] ld, logic ev, int erob,
                              logic [31:0] es1, logic [31:0] es2, int ecnt, logic erdy);
    vec_t v;
    v.chk = c; v.rst_n = r; v.fl = f; v.dv = dv; v.rob = rob;
    v.s1r = s1r; v.s1t = s1t; v.s2r = s2r; v.s2t = s2t;
    v.av = av; v.at = at; v.ad = ad; v.lv = lv; v.lt = lt; v.ld = ld;
    v.e_valid = ev; v.e_rob = erob; v.e_s1 = es1; v.e_s2 = es2; v.e_cnt = ecnt; v.e_rdy = erdy;
    return v;
  endfunction

  // idle cycle with expectations only
  function automatic vec_t idle(logic ev, int erob, logic [31:0] es1, logic [31:0] es2, int ecnt, logic erdy);
    return mk(1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, ev, erob, es1, es2, ecnt, erdy);
  endfunction

  vec_t v;

  initial begin
    rst_aL = 0; flush = 0; alu_v = 0; ld_v = 0;
    alu_t = '0; ld_t = '0; alu_d = '0; ld_d = '0;
    drive(0, 0, 1, 0, 0, 1, 0, 0, 0, 0);

    //           chk rst fl dv rob s1r s1t s2r s2t av at ad            lv lt ld     ev rob es1           es2       cnt rdy
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0,  1, 0,  0, 0, 0,            0, 0, 0,     0, 0,  0,            0,         0, 1));
    vecs.push_back(mk(1, 1, 0, 1, 3,  1, 0,  1, 0,  0, 0, 0,            0, 0, 0,     0, 0,  0,            0,         0, 1));
    vecs.push_back(idle(1, 3, 32'h103, 32'h203, 1, 1));
    vecs.push_back(idle(0, 0, 0, 0, 0, 1));
    // older waiting entry is bypassed, then woken by the ALU
    vecs.push_back(mk(1, 1, 0, 1, 1,  0, 9,  1, 0,  0, 0, 0,            0, 0, 0,     0, 0,  0,            0,         0, 1));
    vecs.push_back(mk(1, 1, 0, 1, 2,  1, 0,  1, 0,  0, 0, 0,            0, 0, 0,     0, 0,  0,            0,         1, 1));
    vecs.push_back(idle(1, 2, 32'h102, 32'h202, 2, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0,  1, 0,  1, 0,  1, 9, 32'hDEADBEEF, 0, 0, 0,     0, 0,  0,            0,         1, 1));
    vecs.push_back(idle(1, 1, 32'hDEADBEEF, 32'h201, 1, 1));
    vecs.push_back(idle(0, 0, 0, 0, 0, 1));
    // fill to full with waiting entries
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 1, 0, 1, 10 + i, 0, 20 + i, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, i, 1));
    vecs.push_back(mk(1, 1, 0, 1, 30, 1, 0,  1, 0,  1, 20, 32'h55,      0, 0, 0,     0, 0,  0,            0,         8, 0));
    vecs.push_back(mk(1, 1, 0, 1, 30, 1, 0,  1, 0,  0, 0, 0,            0, 0, 0,     1, 10, 32'h55,       32'h20A,   8, 0));
    vecs.push_back(idle(0, 0, 0, 0, 7, 1));
    vecs.push_back(mk(1, 1, 1, 1, 31, 1, 0,  1, 0,  0, 0, 0,            0, 0, 0,     0, 0,  0,            0,         7, 1));
    vecs.push_back(idle(0, 0, 0, 0, 0, 1));
    // flush with 5 queued and a concurrent dispatch
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1, 1, 0, 1, 40 + i, 0, 50, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, i, 1));
    vecs.push_back(mk(1, 1, 1, 1, 45, 1, 0,  1, 0,  0, 0, 0,            0, 0, 0,     0, 0,  0,            0,         5, 1));
    vecs.push_back(idle(0, 0, 0, 0, 0, 1));
    vecs.push_back(idle(0, 0, 0, 0, 0, 1));
    // dispatch snoops a load broadcast
    vecs.push_back(mk(1, 1, 0, 1, 6,  1, 0,  0, 5,  0, 0, 0,            1, 5, 32'h12, 0, 0, 0,            0,         0, 1));
    vecs.push_back(idle(1, 6, 32'h106, 32'h12, 1, 1));
    vecs.push_back(idle(0, 0, 0, 0, 0, 1));
    // two entries woken together, third enqueued while they issue
    vecs.push_back(mk(1, 1, 0, 1, 7,  0, 60, 1, 0,  0, 0, 0,            0, 0, 0,     0, 0,  0,            0,         0, 1));
    vecs.push_back(mk(1, 1, 0, 1, 8,  0, 60, 1, 0,  0, 0, 0,            0, 0, 0,     0, 0,  0,            0,         1, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0,  1, 0,  1, 0,  1, 60, 32'h77,      0, 0, 0,     0, 0,  0,            0,         2, 1));
    vecs.push_back(mk(1, 1, 0, 1, 11, 1, 0,  1, 0,  0, 0, 0,            0, 0, 0,     1, 7,  32'h77,       32'h207,   2, 1));
    vecs.push_back(idle(1, 8,  32'h77,  32'h208, 2, 1));
    vecs.push_back(idle(1, 11, 32'h10B, 32'h20B, 1, 1));
    vecs.push_back(idle(0, 0, 0, 0, 0, 1));
    // reset mid-operation drops contents and a concurrent dispatch
    vecs.push_back(mk(1, 1, 0, 1, 12, 0, 1,  1, 0,  0, 0, 0,            0, 0, 0,     0, 0,  0,            0,         0, 1));
    vecs.push_back(mk(1, 1, 0, 1, 13, 0, 1,  1, 0,  0, 0, 0,            0, 0, 0,     0, 0,  0,            0,         1, 1));
    vecs.push_back(mk(1, 0, 0, 1, 14, 1, 0,  1, 0,  0, 0, 0,            0, 0, 0,     0, 0,  0,            0,         2, 1));
    vecs.push_back(idle(0, 0, 0, 0, 0, 1));
    // both buses match the same source: ALU value is kept
    vecs.push_back(mk(1, 1, 0, 1, 15, 0, 2,  1, 0,  0, 0, 0,            0, 0, 0,     0, 0,  0,            0,         0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0,  1, 0,  1, 0,  1, 2, 32'hAAAA,     1, 2, 32'hBBBB, 0, 0, 0,          0,         1, 1));
    vecs.push_back(idle(1, 15, 32'hAAAA, 32'h20F, 1, 1));
    vecs.push_back(idle(0, 0, 0, 0, 0, 1));

    foreach (vecs[k]) begin
      v = vecs[k];
      rst_aL = v.rst_n; flush = v.fl;
      alu_v = v.av; alu_t = 6'(v.at); alu_d = v.ad;
      ld_v  = v.lv; ld_t  = 6'(v.lt); ld_d  = v.ld;
      drive(v.dv, v.rob, v.s1r, v.s1t, v.s1r ? 32'(32'h100 + v.rob) : 32'h0,
            v.s2r, v.s2t, v.s2r ? 32'(32'h200 + v.rob) : 32'h0,
            32'(32'h1000 + v.rob * 4), 32'(v.rob * 3));
      @(negedge clk);
      $display("vec %0d: valid=%0b rob=%0d cnt=%0d rdy=%0b", k, iss.entry_valid, iss.instr_rob_id, count, dispatch_ready);
      if (v.chk) begin
        chk($sformatf("v%0d_valid", k), 32'(iss.entry_valid), 32'(v.e_valid));
        chk($sformatf("v%0d_count", k), 32'(count),           32'(v.e_cnt));
        chk($sformatf("v%0d_ready", k), 32'(dispatch_ready),  32'(v.e_rdy));
        if (v.e_valid) begin
          chk($sformatf("v%0d_rob", k),  32'(iss.instr_rob_id), 32'(v.e_rob));
          chk($sformatf("v%0d_src1", k), iss.src1_data,         v.e_s1);
          chk($sformatf("v%0d_src2", k), iss.src2_data,         v.e_s2);
        end
      end
      if (model_live) check_model();
      @(posedge clk);
      model_update();
      #1;
    end

    // ---------------- randomized traffic against the model ----------------
    for (int c = 0; c < 3000; c++) begin
      rst_aL = ($urandom_range(0, 299) != 0);
      flush  = ($urandom_range(0, 59) == 0);
      alu_v  = ($urandom_range(0, 1) == 1);
      alu_t  = 6'($urandom_range(0, 15));
      alu_d  = $urandom();
      ld_v   = ($urandom_range(0, 1) == 1);
      ld_t   = ($urandom_range(0, 7) == 0) ? alu_t : 6'($urandom_range(0, 15));
      ld_d   = $urandom();
      drive($urandom_range(0, 2) != 0, int'($urandom_range(0, 63)),
            $urandom_range(0, 3) == 0, int'($urandom_range(0, 15)), $urandom(),
            $urandom_range(0, 3) == 0, int'($urandom_range(0, 15)), $urandom(),
            $urandom(), $urandom());
      @(negedge clk);
      if (iss.entry_valid)
        $display("rnd %0d: issue rob=%0d cnt=%0d", c, iss.instr_rob_id, count);
      check_model();
      @(posedge clk);
      model_update();
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/integer_issue_queue.md
Name: integer_issue_queue

Overview:
Holds dispatched integer instructions until both source operands are available. Captures operands from the ALU and load result broadcasts and issues one ready instruction per cycle, oldest first. The issued instruction is driven on iiq_issue_data, which the integer execute stage consumes with no back-pressure. The block sits between dispatch and integer execute and produces every field of iiq_issue_data_t.

Parameters:
N_ENTRIES, 8, number of queue slots (power of 2, >= 2)
CNT_WIDTH, $clog2(N_ENTRIES+1), width of the occupancy counter

Ports:
clk  in  1  clock
rst_aL  in  1  synchronous reset, active low
dispatch_valid  in  1  dispatch offers an instruction
dispatch_ready  out  1  queue accepts an instruction this cycle
dispatch_data  in  iiq_dispatch_data_t  carries the full issue payload plus src1_ready/src1_rob_id/src1_data and src2_ready/src2_rob_id/src2_data
alu_broadcast_valid  in  1  ALU result valid
alu_broadcast_rob_id  in  rob_id_t  producer tag of the ALU result
alu_broadcast_data  in  reg_data_t  ALU result value
ld_broadcast_valid  in  1  load result valid
ld_broadcast_rob_id  in  rob_id_t  producer tag of the load result
ld_broadcast_data  in  reg_data_t  load result value
flush  in  1  pipeline flush (branch mispredict or exception)
iiq_issue_data  out  iiq_issue_data_t  issued instruction; entry_valid qualifies it
iiq_count  out  CNT_WIDTH  current occupancy

Behaviour:
- Storage is a collapsing queue. Slot 0 is the oldest entry. Valid slots are contiguous from slot 0.
- Each slot holds the payload plus, per source: ready, rob_id and data.
- Reset, sampled on the clk edge while rst_aL=0:
  - all slots invalid, iiq_count=0
  - iiq_issue_data.entry_valid=0, dispatch_ready=1
  - other payload fields are don't-care while entry_valid=0
- dispatch_ready = (iiq_count != N_ENTRIES). It depends only on registered state. A slot freed by an issue in the same cycle does not make a full queue ready.
- Enqueue happens when dispatch_valid & dispatch_ready & !flush. The new entry is written at the tail slot that exists after this cycle's collapse.
- Select and issue:
  - A slot is issuable when it is valid and both sources are ready, using the registered ready bits.
  - The lowest-index issuable slot is chosen. Its payload drives iiq_issue_data combinationally in the same cycle, with entry_valid=1, src1_data/src2_data taken from the slot, and instr_rob_id, imm, pc, funct3, the type flags, is_sub, is_sra_srai, is_lui, is_jalr and br_dir_pred passed through unchanged.
  - If no slot is issuable, entry_valid=0.
  - At the clk edge the issued slot is removed. Slots above it shift down by one, and iiq_count decrements.
- Wakeup:
  - On each edge, a valid slot captures a source when that source is not ready, the broadcast is valid and the broadcast rob_id equals the source rob_id. It then sets ready=1 and latches the broadcast data.
  - The ALU and load broadcasts are compared independently. If both match the same source (illegal), the ALU broadcast wins.
  - A source woken at edge t can first be selected in the cycle that follows edge t. There is no same-cycle wakeup-to-select.
  - Capture applies to a slot's post-collapse position, so a shifting entry keeps its wakeup.
- Dispatch snoop: an entry enqueued in a cycle with a matching broadcast captures it. It enters the queue already ready and is issuable in the next cycle.
- Counter:
  - iiq_count_next = iiq_count + enq - issue.
  - Enqueue and issue in the same cycle leave the count unchanged.
  - Overflow and underflow are impossible by construction. A simulation assertion flags either.
- flush:
  - At the edge, all slots become invalid and iiq_count=0.
  - A concurrent enqueue is dropped.
  - iiq_issue_data in the flush cycle is still driven from the current state. The ROB discards it.
- Reset asserted mid-operation behaves exactly like flush and also forces dispatch_ready=1 on the following cycle.
- Only data tagged by rob_id is stored, so rob_id wrap-around needs no handling.

Test Plan:
- Reset, then dispatch one entry with both sources ready (rob_id=3) → the next cycle has entry_valid=1, instr_rob_id=3 and iiq_count=1; the cycle after has entry_valid=0 and iiq_count=0.
- Enqueue rob 1 (src1 waiting on rob 9) then rob 2 (ready) → rob 2 issues first. ALU broadcast rob_id=9, data=0xDEADBEEF → rob 1 issues one cycle later with src1_data=0xDEADBEEF.
- Fill 8 entries that are all waiting → dispatch_ready=0 and iiq_count=8. Wake slot 0 → it issues, and the following cycle dispatch_ready=1.
- Dispatch an entry with src2 waiting on rob 5 in the same cycle as ld_broadcast rob_id=5, data=0x12 → the entry issues the next cycle with src2_data=0x12.
- With 5 entries queued, assert flush together with dispatch_valid → the next cycle has iiq_count=0, entry_valid=0 and no enqueue.
- Two ready entries at slots 0 and 1 while enqueueing a third → they issue on consecutive cycles in age order, the new entry follows, and iiq_count goes 2→2→1→0.
